// File: rtl/pipe_pkg.sv
// Shared types and constants for the parametrised 5-stage integer pipeline.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_XOR = 4'd3,
    ALU_OR  = 4'd4,
    ALU_AND = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RS2   = 2'b00,
    SRC_IMM   = 2'b01,
    SRC_SHAMT = 2'b10
  } alu_src_e;

  // Instruction field positions (instructions are always 32 bits).
  localparam int OP_W      = 8;
  localparam int REG_W     = 5;
  localparam int RD_LSB    = 27;
  localparam int RS1_LSB   = 22;
  localparam int RS2_LSB   = 17;
  localparam int SHAMT_LSB = 8;
  localparam int SHAMT_W   = 9;
  localparam int IMM_LSB   = 8;
  localparam int IMM_W     = 14;
  localparam int JADDR_LSB = 8;

  // Pull a register index out of an instruction word.
  function automatic logic [REG_W-1:0] reg_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: REG_W];
  endfunction

  // Pipeline registers carry control and indices only; the XLEN-wide
  // payloads sit next to them in the top, since a package cannot be
  // parametrised by XLEN.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } IfId_t;

  typedef struct packed {
    logic               valid;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic [1:0]         alu_src;
    logic [3:0]         alu_op;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;
  } IdEx_t;

  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } ExMem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } MemWb_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational XLEN-wide ALU; unknown op codes fall back to add.
module pipe_alu
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  // Operation select; every result wraps at XLEN.
  always_comb begin
    // NOTE: default assignment first so no path leaves y unassigned (no latch).
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_MUL: y = a * b;
      ALU_XOR: y = a ^ b;
      ALU_OR:  y = a | b;
      ALU_AND: y = a & b;
      ALU_SLL: y = a << sh;
      ALU_SRA: y = $signed(a) >>> sh;
      ALU_SRL: y = a >> sh;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath_fwd.sv
// 5-stage IF/ID/EX/MEM/WB datapath with EX forwarding, load-use stall,
// jump flush and optional hard-zero r0. Memories are external.
module pipelined_datapath_fwd
  import pipe_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          IMEM_AW  = 7,
  parameter int          DMEM_AW  = 7,
  parameter int unsigned PC_RESET = 0,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemToReg,
  input  logic               RegWrite,
  input  logic               Jump,
  input  logic [1:0]         ALUSrc,
  input  logic [3:0]         ALUOp,
  output logic [7:0]         Op,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [XLEN-1:0]    wb_data
);

  localparam logic [IMEM_AW-1:0] PC_INIT = IMEM_AW'(PC_RESET);

  // Pipeline state
  logic [IMEM_AW-1:0] pc_q, pc_d;
  IfId_t              if_id_q, if_id_d;
  IdEx_t              id_ex_q, id_ex_d;
  logic [XLEN-1:0]    id_ex_a_q, id_ex_a_d, id_ex_b_q, id_ex_b_d;
  ExMem_t             ex_mem_q, ex_mem_d;
  logic [XLEN-1:0]    ex_mem_res_q, ex_mem_res_d, ex_mem_sd_q, ex_mem_sd_d;
  MemWb_t             mem_wb_q, mem_wb_d;
  logic [XLEN-1:0]    mem_wb_data_q, mem_wb_data_d;
  logic [XLEN-1:0]    rf_q [32];

  // ID decode
  logic [REG_W-1:0] id_rd, id_rs1, id_rs2;
  logic [XLEN-1:0]  id_a, id_b;
  logic             stall, id_jump;

  // EX
  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_y;
  logic            exm_fwd, wb_we;

  assign id_rd  = reg_field(if_id_q.instr, RD_LSB);
  assign id_rs1 = reg_field(if_id_q.instr, RS1_LSB);
  assign id_rs2 = reg_field(if_id_q.instr, RS2_LSB);

  // A retiring write lands in the RF; r0 writes vanish in hard-zero mode.
  assign wb_we = mem_wb_q.valid && mem_wb_q.reg_write && !(R0_ZERO && mem_wb_q.rd == '0);

  // Loads cannot forward from MEM (data not back yet), so ExMem only forwards ALU results.
  assign exm_fwd = ex_mem_q.valid && ex_mem_q.reg_write && !ex_mem_q.mem_to_reg &&
                   !(R0_ZERO && ex_mem_q.rd == '0);

  assign id_jump = if_id_q.valid && Jump;
  assign stall   = if_id_q.valid && !Jump && id_ex_q.valid && id_ex_q.mem_read &&
                   id_ex_q.reg_write && (id_ex_q.rd == id_rs1 || id_ex_q.rd == id_rs2);

  // ID register read with write-through of the value retiring this cycle.
  always_comb begin
    id_a = rf_q[id_rs1];
    if (wb_we && mem_wb_q.rd == id_rs1) id_a = mem_wb_data_q;
    if (R0_ZERO && id_rs1 == '0)        id_a = '0;
    id_b = rf_q[id_rs2];
    if (wb_we && mem_wb_q.rd == id_rs2) id_b = mem_wb_data_q;
    if (R0_ZERO && id_rs2 == '0)        id_b = '0;
  end

  // PC, IF/ID and ID/EX next state: stall holds the front end, jump flushes the fetch.
  always_comb begin
    pc_d           = pc_q + IMEM_AW'(4);
    if_id_d.valid  = 1'b1;
    if_id_d.instr  = imem_rdata;
    id_ex_d        = '0;
    id_ex_a_d      = '0;
    id_ex_b_d      = '0;
    if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
    end else if (id_jump) begin
      pc_d          = if_id_q.instr[JADDR_LSB +: IMEM_AW];
      if_id_d.valid = 1'b0;
    end
    if (if_id_q.valid && !stall) begin
      id_ex_d.valid      = 1'b1;
      id_ex_d.mem_read   = MemRead;
      id_ex_d.mem_write  = MemWrite;
      id_ex_d.mem_to_reg = MemToReg;
      id_ex_d.reg_write  = RegWrite;
      id_ex_d.alu_src    = ALUSrc;
      id_ex_d.alu_op     = ALUOp;
      id_ex_d.rd         = id_rd;
      id_ex_d.rs1        = id_rs1;
      id_ex_d.rs2        = id_rs2;
      id_ex_d.imm        = if_id_q.instr[IMM_LSB +: IMM_W];
      id_ex_d.shamt      = if_id_q.instr[SHAMT_LSB +: SHAMT_W];
      id_ex_a_d          = id_a;
      id_ex_b_d          = id_b;
    end
  end

  // EX operand forwarding: the younger producer in ExMem overrides MemWb.
  always_comb begin
    fwd_a = id_ex_a_q;
    if (wb_we && mem_wb_q.rd == id_ex_q.rs1)    fwd_a = mem_wb_data_q;
    if (exm_fwd && ex_mem_q.rd == id_ex_q.rs1)  fwd_a = ex_mem_res_q;
    fwd_b = id_ex_b_q;
    if (wb_we && mem_wb_q.rd == id_ex_q.rs2)    fwd_b = mem_wb_data_q;
    if (exm_fwd && ex_mem_q.rd == id_ex_q.rs2)  fwd_b = ex_mem_res_q;
  end

  // ALU second operand select.
  always_comb begin
    alu_b = fwd_b;
    case (id_ex_q.alu_src)
      SRC_IMM:   alu_b = {{(XLEN-IMM_W){id_ex_q.imm[IMM_W-1]}}, id_ex_q.imm};
      SRC_SHAMT: alu_b = {{(XLEN-SHAMT_W){1'b0}}, id_ex_q.shamt};
      default:   alu_b = fwd_b;
    endcase
  end

  pipe_alu #(.XLEN(XLEN)) u_alu (
    .a  (fwd_a),
    .b  (alu_b),
    .op (id_ex_q.alu_op),
    .y  (alu_y)
  );

  // EX/MEM and MEM/WB next state; bubbles carry zero control so they never act.
  always_comb begin
    ex_mem_d.valid      = id_ex_q.valid;
    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_res_d        = alu_y;
    ex_mem_sd_d         = fwd_b;
    mem_wb_d.valid      = ex_mem_q.valid;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.rd         = ex_mem_q.rd;
    mem_wb_data_d       = ex_mem_q.mem_to_reg ? dmem_rdata : ex_mem_res_q;
  end

  // Pipeline registers; reset empties every stage.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge values of its neighbours.
    if (reset) begin
      pc_q          <= PC_INIT;
      if_id_q       <= '0;
      id_ex_q       <= '0;
      id_ex_a_q     <= '0;
      id_ex_b_q     <= '0;
      ex_mem_q      <= '0;
      ex_mem_res_q  <= '0;
      ex_mem_sd_q   <= '0;
      mem_wb_q      <= '0;
      mem_wb_data_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      id_ex_q       <= id_ex_d;
      id_ex_a_q     <= id_ex_a_d;
      id_ex_b_q     <= id_ex_b_d;
      ex_mem_q      <= ex_mem_d;
      ex_mem_res_q  <= ex_mem_res_d;
      ex_mem_sd_q   <= ex_mem_sd_d;
      mem_wb_q      <= mem_wb_d;
      mem_wb_data_q <= mem_wb_data_d;
    end
  end

  // Register file write port.
  always_ff @(posedge clk) begin
    // NOTE: the RF has no reset so it maps onto plain RAM/flops without a reset tree.
    if (wb_we) rf_q[mem_wb_q.rd] <= mem_wb_data_q;
  end

  assign Op         = if_id_q.valid ? if_id_q.instr[OP_W-1:0] : '0;
  assign imem_addr  = pc_q;
  assign dmem_addr  = ex_mem_res_q[DMEM_AW-1:0];
  assign dmem_re    = ex_mem_q.valid && ex_mem_q.mem_read;
  assign dmem_we    = ex_mem_q.valid && ex_mem_q.mem_write;
  assign dmem_wdata = ex_mem_sd_q;
  assign wb_valid   = mem_wb_q.valid && mem_wb_q.reg_write;
  assign wb_rd      = wb_valid ? mem_wb_q.rd : '0;
  assign wb_data    = wb_valid ? mem_wb_data_q : '0;

endmodule
